// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs 32-bit message words into padded 512-bit SHA-256 blocks
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);
  typedef enum logic {FILL, OUT} state_t;
  state_t state, state_d;
  logic [511:0] buf_q, fill_buf;
  logic [3:0] w_idx;
  logic [LEN_W-1:0] len, len_nx;
  logic [63:0] len_field, len_cur;
  logic [31:0] last_word;
  logic extra_pend, extra_w0, new_msg, first_q, last_q, k4, fits, acc;
  assign in_ready  = state == FILL;
  assign blk_valid = state == OUT;
  assign blk_data  = buf_q;
  assign blk_first = first_q;
  assign blk_last  = last_q;
  always_comb begin
    acc       = in_valid && in_ready;
    k4        = in_nbytes[2];
    len_nx    = len + LEN_W'({in_nbytes, 3'b000});
    len_field = 64'(len_nx);
    len_cur   = 64'(len);
    fits      = w_idx <= (k4 ? 4'd12 : 4'd13);
    last_word = (in_data & ~(32'hffff_ffff >> {in_nbytes, 3'b000}))
              | (k4 ? 32'h0 : 32'h8000_0000 >> {in_nbytes, 3'b000});
    fill_buf = buf_q;
    fill_buf[{~w_idx, 5'd0} +: 32] = in_last ? last_word : in_data;
    if (in_last && k4 && !(&w_idx)) fill_buf[{~(w_idx + 4'd1), 5'd0} +: 32] = 32'h8000_0000;
    if (in_last && fits) fill_buf[63:0] = len_field;
    state_d = state == FILL ? (acc && (in_last || &w_idx) ? OUT : FILL)
                            : (blk_ready && !extra_pend ? FILL : OUT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      buf_q      <= '0;
      w_idx      <= '0;
      len        <= '0;
      extra_pend <= 1'b0;
      extra_w0   <= 1'b0;
      new_msg    <= 1'b1;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state <= state_d;
      if (state == FILL && acc) begin
        buf_q <= fill_buf;
        len   <= len_nx;
        w_idx <= in_last ? 4'd0 : w_idx + 4'd1;
        if (in_last || &w_idx) begin
          first_q    <= new_msg;
          new_msg    <= 1'b0;
          last_q     <= in_last && fits;
          extra_pend <= in_last && !fits;
          extra_w0   <= in_last && k4 && &w_idx;
        end
      end else if (state == OUT && blk_ready) begin
        if (extra_pend) begin
          buf_q      <= {extra_w0 ? 32'h8000_0000 : 32'h0, 416'h0, len_cur};
          extra_pend <= 1'b0;
          first_q    <= 1'b0;
          last_q     <= 1'b1;
        end else begin
          buf_q   <= '0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          if (last_q) begin
            len     <= '0;
            new_msg <= 1'b1;
          end
        end
      end
    end
  end
endmodule
